// File: rtl/instr_dcd_burst.sv
// rtl/instr_dcd_burst.sv - SPI instruction decoder with multi-byte words and burst address auto-increment
// Optional frame-abort timeout is built only when INSTR_DCD_TIMEOUT_EN is defined.
module instr_dcd_burst #(
   parameter int ADDR_W      = 6,
   parameter int DATA_BYTES  = 1,
   parameter int TIMEOUT_CYC = 1024,
   localparam int DATA_W     = 8 * DATA_BYTES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_sync,
   input  logic [7:0]        data_in,
   input  logic              frame_end,
   output logic [7:0]        data_out,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_read,
   output logic [DATA_W-1:0] data_write,
   output logic              err_timeout
);

   localparam logic [0:0] ST_HDR   = 1'b0;
   localparam logic [0:0] ST_DATA  = 1'b1;
   localparam logic [1:0] LAST_IDX = 2'(DATA_BYTES - 1);

   logic [0:0]        state;
   logic [1:0]        idx;
   logic              rw;
   logic              burst;
   logic              capture;
   logic              abort;
   logic [DATA_W-1:0] asm_word;
   logic [DATA_W-1:0] next_word;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_shift;

   assign next_word = (asm_word << 8) | DATA_W'(data_in);

   // MSB-first: byte index 0 is the top byte of the captured word
   assign rd_shift = rd_word << {idx, 3'b000};
   assign data_out = rd_shift[DATA_W-1 -: 8];

`ifdef INSTR_DCD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] to_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (state != ST_DATA || byte_sync || frame_end) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign abort = (state == ST_DATA) && !byte_sync && !frame_end &&
                  (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= abort;
      end
   end
`else
   assign abort       = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_HDR;
         idx        <= '0;
         rw         <= 1'b0;
         burst      <= 1'b0;
         addr       <= '0;
         asm_word   <= '0;
         data_write <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         capture    <= 1'b0;
         rd_word    <= '0;
      end else begin
         read    <= 1'b0;
         write   <= 1'b0;
         capture <= read;
         if (capture) begin
            rd_word <= data_read;
         end
         // burst writes step the address once the strobe has been seen
         if (write && burst) begin
            addr <= addr + 1'b1;
         end
         if (frame_end || abort) begin
            state    <= ST_HDR;
            idx      <= '0;
            asm_word <= '0;
         end else if (byte_sync) begin
            if (state == ST_HDR) begin
               rw       <= data_in[7];
               burst    <= data_in[6];
               addr     <= data_in[ADDR_W-1:0];
               read     <= ~data_in[7];
               idx      <= '0;
               asm_word <= '0;
               state    <= ST_DATA;
            end else begin
               asm_word <= next_word;
               if (idx == LAST_IDX) begin
                  idx      <= '0;
                  asm_word <= '0;
                  if (rw) begin
                     data_write <= next_word;
                     write      <= 1'b1;
                  end else if (burst) begin
                     addr <= addr + 1'b1;
                     read <= 1'b1;
                  end
                  if (!burst) begin
                     state <= ST_HDR;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_dcd_burst.sv
// tb/tb_instr_dcd_burst.sv - directed and randomized frames on instr_dcd_burst checked against a frame-level model
`timescale 1ns/1ps
module tb_instr_dcd_burst;

   typedef struct packed {
      logic        inst;
      logic        wr;
      logic [5:0]  a;
      logic [15:0] d;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        bs [2];
   logic [7:0]  din [2];
   logic        fe [2];
   logic [7:0]  dout0, dout1;
   logic        rd0, rd1, wr0, wr1, to0, to1;
   logic [5:0]  ad0, ad1;
   logic [7:0]  dw0, drd0;
   logic [15:0] dw1, drd1;

   instr_dcd_burst #(.ADDR_W(6), .DATA_BYTES(1), .TIMEOUT_CYC(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .byte_sync(bs[0]), .data_in(din[0]), .frame_end(fe[0]),
      .data_out(dout0), .read(rd0), .write(wr0), .addr(ad0), .data_read(drd0),
      .data_write(dw0), .err_timeout(to0));

   instr_dcd_burst #(.ADDR_W(6), .DATA_BYTES(2), .TIMEOUT_CYC(16)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .byte_sync(bs[1]), .data_in(din[1]), .frame_end(fe[1]),
      .data_out(dout1), .read(rd1), .write(wr1), .addr(ad1), .data_read(drd1),
      .data_write(dw1), .err_timeout(to1));

   int errors = 0;
   int checks = 0;
   int viol = 0;
   int to_cnt = 0;
   int to_exp = 0;
   logic prev_s0 = 1'b0;
   logic prev_s1 = 1'b0;

   logic [15:0] regmem [2][64];
   logic [15:0] ref_mem [2][64];
   ev_t obs_q[$];
   ev_t exp_q[$];
   int  exp_out[$];

   function automatic logic [15:0] init_val(input int k, input int i);
      logic [15:0] v;
      v = 16'(i * 40503 + k * 7919 + 17);
      return (k == 0) ? {8'h00, v[7:0]} : v;
   endfunction

   function automatic ev_t mk_ev(input int k, input logic w, input int a, input logic [15:0] d);
      ev_t e;
      e.inst = 1'(k);
      e.wr   = w;
      e.a    = 6'(a);
      e.d    = d;
      return e;
   endfunction

   function automatic logic [7:0] get_dout(input int k);
      return (k == 0) ? dout0 : dout1;
   endfunction

   // register file: read data appears the cycle after the read strobe, garbage otherwise
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) begin
            regmem[0][i] <= init_val(0, i);
            regmem[1][i] <= init_val(1, i);
         end
      end else begin
         if (wr0) regmem[0][ad0] <= {8'h00, dw0};
         if (wr1) regmem[1][ad1] <= dw1;
      end
      drd0 <= rd0 ? regmem[0][ad0][7:0] : 8'($urandom);
      drd1 <= rd1 ? regmem[1][ad1] : 16'($urandom);
   end

   always @(negedge clk) begin
      if (rd0 || wr0) obs_q.push_back(mk_ev(0, wr0, int'(ad0), wr0 ? {8'h00, dw0} : 16'h0));
      if (rd1 || wr1) obs_q.push_back(mk_ev(1, wr1, int'(ad1), wr1 ? dw1 : 16'h0));
      viol <= viol + int'((rd0 && wr0) || (rd1 && wr1)) +
              int'((prev_s0 && (rd0 || wr0)) || (prev_s1 && (rd1 || wr1)));
      prev_s0 <= rd0 || wr0;
      prev_s1 <= rd1 || wr1;
      to_cnt  <= to_cnt + int'(to0) + int'(to1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic init_ref();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 64; i++)
            ref_mem[k][i] = init_val(k, i);
   endtask

   // frame-level model: strobe events and the byte expected on data_out before each byte slot
   task automatic model_frame(input int k, input logic [7:0] seq[$]);
      int nb, a, cnt;
      bit in_hdr, w, b;
      logic [15:0] acc, word;
      nb = k + 1; a = 0; cnt = 0; in_hdr = 1; w = 0; b = 0; acc = '0; word = '0;
      exp_q.delete();
      exp_out.delete();
      foreach (seq[i]) begin
         if (in_hdr) begin
            exp_out.push_back(-1);
            w = seq[i][7]; b = seq[i][6]; a = int'(seq[i][5:0]);
            cnt = 0; acc = '0; in_hdr = 0;
            if (!w) begin
               exp_q.push_back(mk_ev(k, 1'b0, a, 16'h0));
               word = ref_mem[k][a];
            end
         end else begin
            if (w) exp_out.push_back(-1);
            else exp_out.push_back(int'((word >> (8 * (nb - 1 - cnt))) & 16'h00ff));
            acc = (acc << 8) | 16'(seq[i]);
            cnt++;
            if (cnt == nb) begin
               cnt = 0;
               if (w) begin
                  exp_q.push_back(mk_ev(k, 1'b1, a, acc));
                  ref_mem[k][a] = acc;
               end
               if (b) begin
                  a = (a + 1) % 64;
                  if (!w) begin
                     exp_q.push_back(mk_ev(k, 1'b0, a, 16'h0));
                     word = ref_mem[k][a];
                  end
               end else begin
                  in_hdr = 1;
               end
               acc = '0;
            end
         end
      end
   endtask

   task automatic send_byte(input int k, input logic [7:0] b);
      @(negedge clk);
      bs[k] = 1'b1;
      din[k] = b;
      @(negedge clk);
      bs[k] = 1'b0;
   endtask

   task automatic pulse_fe(input int k);
      @(negedge clk);
      fe[k] = 1'b1;
      @(negedge clk);
      fe[k] = 1'b0;
   endtask

   task automatic compare_events(input string tag);
      int n;
      chk($sformatf("%s event count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s event %0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
   endtask

   task automatic run_frame(input string tag, input int k, input logic [7:0] seq[$]);
      model_frame(k, seq);
      obs_q.delete();
      foreach (seq[i]) begin
         if (exp_out[i] >= 0)
            chk($sformatf("%s data_out byte%0d", tag, i), 32'(get_dout(k)), 32'(exp_out[i]));
         send_byte(k, seq[i]);
         repeat ($urandom_range(2, 5)) @(negedge clk);
      end
      pulse_fe(k);
      repeat (3) @(negedge clk);
      compare_events(tag);
   endtask

   initial begin
      logic [7:0] seq[$];
      int k;
      for (int j = 0; j < 2; j++) begin
         bs[j] = 1'b0; din[j] = 8'h00; fe[j] = 1'b0;
      end
      init_ref();
      repeat (3) @(negedge clk);
      chk("reset read0", 32'(rd0), 0);       chk("reset read1", 32'(rd1), 0);
      chk("reset write0", 32'(wr0), 0);      chk("reset write1", 32'(wr1), 0);
      chk("reset addr0", 32'(ad0), 0);       chk("reset addr1", 32'(ad1), 0);
      chk("reset dwrite0", 32'(dw0), 0);     chk("reset dwrite1", 32'(dw1), 0);
      chk("reset dout0", 32'(dout0), 0);     chk("reset dout1", 32'(dout1), 0);
      chk("reset err0", 32'(to0), 0);        chk("reset err1", 32'(to1), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // second header after a completed non-burst word proves the return to HDR
      seq = '{8'h85, 8'hAB, 8'hCD, 8'h8A, 8'h12, 8'h34};
      run_frame("write2", 1, seq);
      seq = '{8'h0A, 8'h00, 8'h00};
      run_frame("read2", 1, seq);
      seq = '{8'hFE, 8'h11, 8'h22, 8'h33};
      run_frame("burst_wr_wrap", 0, seq);
      seq = '{8'h43, 8'h00, 8'h00, 8'h00};
      run_frame("burst_rd", 0, seq);

      seq = '{8'h81, 8'h55};
      model_frame(1, seq);
      obs_q.delete();
      send_byte(1, 8'h81);
      repeat (3) @(negedge clk);
      send_byte(1, 8'h55);
      repeat (3) @(negedge clk);
      bs[1] = 1'b1; din[1] = 8'h99; fe[1] = 1'b1;
      @(negedge clk);
      bs[1] = 1'b0; fe[1] = 1'b0;
      repeat (3) @(negedge clk);
      compare_events("collision");
      seq = '{8'h07, 8'h00, 8'h00};
      run_frame("after_collision", 1, seq);

      obs_q.delete();
      send_byte(1, 8'h85);
      repeat (3) @(negedge clk);
      send_byte(1, 8'h11);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset write", 32'(wr1), 0);
      chk("midreset addr", 32'(ad1), 0);
      chk("midreset dout", 32'(dout1), 0);
      chk("midreset events", 32'(obs_q.size()), 0);
      rst_n = 1'b1;
      init_ref();
      repeat (2) @(negedge clk);
      seq = '{8'h22, 8'h00, 8'h00};
      run_frame("after_reset", 1, seq);

`ifdef INSTR_DCD_TIMEOUT_EN
      to_exp = 1;
      obs_q.delete();
      send_byte(1, 8'h81);
      repeat (20) @(negedge clk);
      chk("timeout pulses", 32'(to_cnt), 1);
      chk("timeout no write", 32'(obs_q.size()), 0);
      seq = '{8'h07, 8'h00, 8'h00};
      run_frame("after_timeout", 1, seq);
`endif

      for (int r = 0; r < 40; r++) begin
         k = int'($urandom_range(0, 1));
         seq.delete();
         seq.push_back(8'($urandom));
         repeat ($urandom_range(0, 7)) seq.push_back(8'($urandom));
         run_frame($sformatf("rand%0d", r), k, seq);
      end

      chk("strobe rule violations", 32'(viol), 0);
      chk("err_timeout pulses", 32'(to_cnt), 32'(to_exp));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
